// File: rtl/mem_responder_if.sv
// ----------------------------------------------------------------------------
// mem_responder_if
// Request/response channel between an initiator and mem_responder.
//
// Signals:
//   req_valid / req_ready  request handshake
//   req_addr  [31:0]       byte address of the requested line
//   req_id    [ID_W-1:0]   tag, echoed back on rsp_id
//   rsp_valid / rsp_ready  response handshake
//   rsp_id    [ID_W-1:0]   tag of the presented response
//   rsp_data  [LINE_W-1:0] line data of the presented response
//
// Modports:
//   master  initiator side (drives requests, accepts responses)
//   slave   responder side (accepts requests, drives responses)
// ----------------------------------------------------------------------------
interface mem_responder_if #(
    parameter int ID_W   = 4,
    parameter int LINE_W = 128
);
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic [ID_W-1:0]   req_id;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [LINE_W-1:0] rsp_data;

    modport master (
        output req_valid, req_addr, req_id, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, req_id, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/mem_responder.sv
// ----------------------------------------------------------------------------
// mem_responder
// Fixed-latency, in-order memory responder. Accepted requests are queued in a
// circular FIFO of DEPTH entries; each entry carries a countdown timer loaded
// with LATENCY-1. The head entry is answered once its timer reaches zero,
// with data read combinationally from a MEM_LINES x LINE_W backing array.
//
// Ports:
//   clk       sole clock, rising edge
//   reset     asynchronous, active-high
//   bus       mem_responder_if.slave (request/response handshakes)
//   wr_en     backing-array write strobe
//   wr_idx    backing-array write line index
//   wr_data   backing-array write data
//   nuke_rb1  pipeline nuke (only honoured when MEM_RESPONDER_NUKE_EN is
//             defined; otherwise ignored)
//
// Build option:
//   MEM_RESPONDER_NUKE_EN  when defined, nuke_rb1 flushes all outstanding
//                          requests, drops a same-cycle request and masks
//                          rsp_valid in that cycle.
// ----------------------------------------------------------------------------
module mem_responder #(
    parameter int LATENCY   = 5,
    parameter int DEPTH     = 4,
    parameter int MEM_LINES = 256,
    parameter int LINE_W    = 128,
    parameter int ID_W      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    mem_responder_if.slave               bus,
    input  logic                         wr_en,
    input  logic [$clog2(MEM_LINES)-1:0] wr_idx,
    input  logic [LINE_W-1:0]            wr_data,
    input  logic                         nuke_rb1
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int IDX_W = $clog2(MEM_LINES);
    localparam int OCC_W = PTR_W + 1;

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [3:0]       TMR_LOAD = 4'(LATENCY - 1);

    // Backing array (never reset)
    logic [LINE_W-1:0] r_mem [MEM_LINES];

    // Queue control
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [OCC_W-1:0] r_occ;

    // Per-entry views gathered from the entry generate blocks
    logic             w_vld  [DEPTH];
    logic [IDX_W-1:0] w_line [DEPTH];
    logic [ID_W-1:0]  w_id   [DEPTH];
    logic [3:0]       w_tmr  [DEPTH];

    logic             w_nuke;
    logic             w_req_ready;
    logic             w_rsp_valid;
    logic             w_push;
    logic             w_pop;
    logic [IDX_W-1:0] w_req_line;

`ifdef MEM_RESPONDER_NUKE_EN
    assign w_nuke = nuke_rb1;
`else
    logic w_nuke_unused;
    assign w_nuke_unused = nuke_rb1;
    assign w_nuke        = 1'b0;
`endif

    // Only the line-index bits of the address are kept: the offset bits and
    // everything above MEM_LINES are irrelevant to the lookup (modulo wrap).
    assign w_req_line = bus.req_addr[4 +: IDX_W];

    logic w_addr_unused;
    assign w_addr_unused = ^{bus.req_addr[31:4+IDX_W], bus.req_addr[3:0]};

    // req_ready looks only at registered occupancy, so a pop in the same
    // cycle cannot reopen a full queue.
    assign w_req_ready = !reset && (r_occ < OCC_FULL);
    assign w_rsp_valid = !reset && !w_nuke && w_vld[r_head] && (w_tmr[r_head] == '0);
    assign w_push      = bus.req_valid && w_req_ready && !w_nuke;
    assign w_pop       = w_rsp_valid && bus.rsp_ready;

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = w_rsp_valid;
    assign bus.rsp_id    = reset ? '0 : w_id[r_head];
    assign bus.rsp_data  = reset ? '0 : r_mem[w_line[r_head]];

    // Head/tail pointers and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else if (w_nuke) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // FIFO entries. Each slot owns its own flops so every register has a
    // single driver; the head mux above reads them through the w_* arrays.
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic             r_vld;
        logic [3:0]       r_tmr;
        logic [IDX_W-1:0] r_line;
        logic [ID_W-1:0]  r_id;
        logic             w_push_here;
        logic             w_pop_here;

        assign w_push_here = w_push && (r_tail == PTR_W'(g));
        assign w_pop_here  = w_pop  && (r_head == PTR_W'(g));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_vld <= 1'b0;
                r_tmr <= '0;
            end else if (w_nuke) begin
                r_vld <= 1'b0;
                r_tmr <= '0;
            end else if (w_push_here) begin
                r_vld <= 1'b1;
                r_tmr <= TMR_LOAD;
            end else begin
                if (w_pop_here) begin
                    r_vld <= 1'b0;
                end
                if (r_vld && (r_tmr != '0)) begin
                    r_tmr <= r_tmr - 1'b1;
                end
            end
        end

        // Payload needs no reset: it is only observed while r_vld is set.
        always_ff @(posedge clk) begin
            if (w_push_here) begin
                r_line <= w_req_line;
                r_id   <= bus.req_id;
            end
        end

        assign w_vld[g]  = r_vld;
        assign w_tmr[g]  = r_tmr;
        assign w_line[g] = r_line;
        assign w_id[g]   = r_id;
    end

    // Backing-array write; a same-cycle response read sees the old line.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_idx] <= wr_data;
        end
    end
endmodule
